// File: rtl/mem_responder.sv
// mem_responder: single-port word RAM plus IO register and transaction
// counter behind a req/ack handshake with a fixed number of wait states.
//
// Parameters:
//   ADDR_W      - RAM depth is 2**ADDR_W words of 16 bits
//   WAIT_CYCLES - wait states between accept and ack (0..7)
//   IO_BASE     - IO_BASE: io_in/io_out register, IO_BASE+1: txn counter
// Ports:
//   clk, reset (sync, active-high)
//   req, we, addr[15:0], wdata[15:0] - CPU request, sampled in IDLE
//   io_in[15:0]  - external input read at IO_BASE
//   rdata[15:0]  - load data, valid in the ack cycle and held after
//   ack, err     - one-cycle completion / error pulses
//   busy         - high while a transaction is in flight
//   io_out[15:0] - output register written at IO_BASE
// Optional feature: define MEM_RESP_WRITE_PROTECT_EN to reject stores
// to 0x0000..0x00FF.

module mem_responder #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] IO_BASE     = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic [15:0] io_in,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err,
    output logic [15:0] io_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [16:0] RAM_TOP   = 17'(1) << ADDR_W;
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_CYCLES);
    localparam logic [15:0] CNT_ADDR  = IO_BASE + 16'd1;

    state_t      state_q, state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] io_out_q, io_out_d;
    logic [15:0] txn_cnt_q, txn_cnt_d;
    logic        err_q, err_d;
    logic        ram_we;
    logic        enter_ack;
    logic        in_ack;
    logic        ack_io_load;
    logic        nxt_ram, nxt_io, nxt_cnt, nxt_wp, nxt_err;

    logic [15:0] ram [0:(1 << ADDR_W) - 1];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 3'd0;
            addr_q     <= 16'd0;
            wdata_q    <= 16'd0;
            we_q       <= 1'b0;
            rdata_q    <= 16'd0;
            io_out_q   <= 16'd0;
            txn_cnt_q  <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            rdata_q    <= rdata_d;
            io_out_q   <= io_out_d;
            txn_cnt_q  <= txn_cnt_d;
            err_q      <= err_d;
        end
    end

    // RAM has no reset; reset still blocks a pending write
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            ram[addr_q[ADDR_W-1:0]] <= wdata_q;
        end
    end

    // Next-state logic and request capture
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = we;
                    if (WAIT_CYCLES > 0) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 3'd1;
                if (wait_cnt_q <= 3'd1) begin
                    state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Decode of the transaction that is about to enter ACK
    always_comb begin
        nxt_ram = ({1'b0, addr_d} < RAM_TOP);
        nxt_io  = (addr_d == IO_BASE);
        nxt_cnt = (addr_d == CNT_ADDR);
`ifdef MEM_RESP_WRITE_PROTECT_EN
        nxt_wp  = we_d && nxt_ram && (addr_d < 16'h0100);
`else
        nxt_wp  = 1'b0;
`endif
        nxt_err = !(nxt_ram || nxt_io || nxt_cnt)
                  || (nxt_cnt && we_d) || nxt_wp;
    end

    // Datapath: load data is registered on entry to ACK, writes and
    // the counter update happen on the edge that ends ACK.
    always_comb begin
        rdata_d   = rdata_q;
        io_out_d  = io_out_q;
        txn_cnt_d = txn_cnt_q;
        err_d     = 1'b0;
        ram_we    = 1'b0;
        in_ack    = (state_q == S_ACK);
        enter_ack = (state_d == S_ACK) && !in_ack;
        if (enter_ack) begin
            err_d = nxt_err;
            if (!we_d) begin
                if (nxt_err) begin
                    rdata_d = 16'd0;
                end else if (nxt_ram) begin
                    rdata_d = ram[addr_d[ADDR_W-1:0]];
                end else if (nxt_io) begin
                    rdata_d = io_in;
                end else begin
                    rdata_d = txn_cnt_q;
                end
            end
        end
        if (in_ack) begin
            txn_cnt_d = txn_cnt_q + 16'd1;
            // io_in is live during ACK; keep the last value seen
            if (ack_io_load) begin
                rdata_d = io_in;
            end
            if (we_q && !err_q) begin
                if (addr_q == IO_BASE) begin
                    io_out_d = wdata_q;
                end else begin
                    ram_we = 1'b1;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        ack_io_load = (state_q == S_ACK) && !we_q && !err_q
                      && (addr_q == IO_BASE);
        ack    = (state_q == S_ACK);
        busy   = (state_q != S_IDLE);
        err    = err_q;
        io_out = io_out_q;
        rdata  = ack_io_load ? io_in : rdata_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: one instance with
// one wait state and one with none for back-to-back traffic.

module tb_mem_responder;

    logic clk;

    logic        a_reset, a_req, a_we;
    logic [15:0] a_addr, a_wdata, a_io_in;
    logic [15:0] a_rdata, a_io_out;
    logic        a_ack, a_busy, a_err;

    logic        b_reset, b_req, b_we;
    logic [15:0] b_addr, b_wdata, b_io_in;
    logic [15:0] b_rdata, b_io_out;
    logic        b_ack, b_busy, b_err;

    int errors = 0;
    int checks = 0;

    mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1), .IO_BASE(16'hFF00)) u_a (
        .clk(clk), .reset(a_reset), .req(a_req), .we(a_we),
        .addr(a_addr), .wdata(a_wdata), .io_in(a_io_in),
        .rdata(a_rdata), .ack(a_ack), .busy(a_busy), .err(a_err),
        .io_out(a_io_out)
    );

    mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .IO_BASE(16'hFF00)) u_b (
        .clk(clk), .reset(b_reset), .req(b_req), .we(b_we),
        .addr(b_addr), .wdata(b_wdata), .io_in(b_io_in),
        .rdata(b_rdata), .ack(b_ack), .busy(b_busy), .err(b_err),
        .io_out(b_io_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on instance A; returns data/err seen with ack and
    // the number of edges from the accepting edge to the ack cycle.
    task automatic a_txn(input logic w, input logic [15:0] ad,
                         input logic [15:0] wd, output logic [15:0] rd,
                         output logic er, output int lat);
        a_req   = 1'b1;
        a_we    = w;
        a_addr  = ad;
        a_wdata = wd;
        tick();
        a_req = 1'b0;
        lat   = 1;
        while (!a_ack && lat < 10) begin
            tick();
            lat++;
        end
        rd = a_rdata;
        er = a_err;
        tick();
    endtask

    logic [15:0] rd;
    logic        er;
    int          lat;
    int          nack;

    initial begin
        a_reset = 1'b1; a_req = 1'b0; a_we = 1'b0;
        a_addr = 16'd0; a_wdata = 16'd0; a_io_in = 16'd0;
        b_reset = 1'b1; b_req = 1'b0; b_we = 1'b0;
        b_addr = 16'd0; b_wdata = 16'd0; b_io_in = 16'd0;
        tick();
        tick();
        a_reset = 1'b0;
        b_reset = 1'b0;

        chk("rst_ack", 16'(a_ack), 16'd0);
        chk("rst_busy", 16'(a_busy), 16'd0);
        chk("rst_err", 16'(a_err), 16'd0);
        chk("rst_rdata", a_rdata, 16'd0);
        chk("rst_io_out", a_io_out, 16'd0);

        // Store then load RAM, with cycle-by-cycle view of the store
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0200; a_wdata = 16'h1234;
        tick();
        a_req = 1'b0;
        chk("st_wait_busy", 16'(a_busy), 16'd1);
        chk("st_wait_ack", 16'(a_ack), 16'd0);
        tick();
        chk("st_ack", 16'(a_ack), 16'd1);
        chk("st_ack_busy", 16'(a_busy), 16'd1);
        chk("st_err", 16'(a_err), 16'd0);
        chk("st_rdata_held", a_rdata, 16'd0);
        tick();
        chk("st_idle_ack", 16'(a_ack), 16'd0);
        chk("st_idle_busy", 16'(a_busy), 16'd0);

        a_txn(1'b0, 16'h0200, 16'h0, rd, er, lat);
        chk("ld_lat", 16'(lat), 16'd2);
        chk("ld_rdata", rd, 16'h1234);
        chk("ld_err", 16'(er), 16'd0);
        chk("ld_rdata_hold", a_rdata, 16'h1234);

        // IO register
        a_io_in = 16'h00F0;
        a_txn(1'b1, 16'hFF00, 16'hA5A5, rd, er, lat);
        chk("io_st_err", 16'(er), 16'd0);
        chk("io_out", a_io_out, 16'hA5A5);
        chk("io_st_rdata_kept", a_rdata, 16'h1234);
        a_txn(1'b0, 16'hFF00, 16'h0, rd, er, lat);
        chk("io_ld_rdata", rd, 16'h00F0);
        chk("io_ld_err", 16'(er), 16'd0);

        // RAM boundary
        a_txn(1'b1, 16'h03FF, 16'h5A5A, rd, er, lat);
        chk("top_st_err", 16'(er), 16'd0);
        a_txn(1'b0, 16'h03FF, 16'h0, rd, er, lat);
        chk("top_ld_rdata", rd, 16'h5A5A);
        a_txn(1'b0, 16'h0400, 16'h0, rd, er, lat);
        chk("beyond_err", 16'(er), 16'd1);
        chk("beyond_rdata", rd, 16'h0000);

        // Errors and the transaction counter, from a fresh reset
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        chk("rst2_io_out", a_io_out, 16'd0);
        a_txn(1'b0, 16'h8000, 16'h0, rd, er, lat);
        chk("unmap_lat", 16'(lat), 16'd2);
        chk("unmap_err", 16'(er), 16'd1);
        chk("unmap_rdata", rd, 16'h0000);
        a_txn(1'b0, 16'hFF01, 16'h0, rd, er, lat);
        chk("cnt_rdata", rd, 16'h0001);
        chk("cnt_err", 16'(er), 16'd0);
        a_txn(1'b1, 16'hFF01, 16'h7777, rd, er, lat);
        chk("cnt_st_err", 16'(er), 16'd1);
        a_txn(1'b0, 16'hFF01, 16'h0, rd, er, lat);
        chk("cnt_after_err", rd, 16'h0003);

        // Reset in the WAIT state of a store
        a_txn(1'b1, 16'h0300, 16'h1111, rd, er, lat);
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0300; a_wdata = 16'hBEEF;
        tick();
        a_req = 1'b0;
        chk("abort_busy", 16'(a_busy), 16'd1);
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        chk("abort_ack", 16'(a_ack), 16'd0);
        chk("abort_busy0", 16'(a_busy), 16'd0);
        tick();
        chk("abort_ack2", 16'(a_ack), 16'd0);
        a_txn(1'b0, 16'hFF01, 16'h0, rd, er, lat);
        chk("abort_cnt", rd, 16'h0000);
        a_txn(1'b0, 16'h0300, 16'h0, rd, er, lat);
        chk("abort_ram", rd, 16'h1111);

        // Write-protect window
        a_txn(1'b1, 16'h0010, 16'h7777, rd, er, lat);
`ifdef MEM_RESP_WRITE_PROTECT_EN
        chk("wp_st_err", 16'(er), 16'd1);
        a_txn(1'b0, 16'h0010, 16'h0, rd, er, lat);
        chk("wp_ld_err", 16'(er), 16'd0);
        checks++;
        assert (rd !== 16'h7777) else begin
            errors++;
            $error("FAIL wp_ram_unchanged: observed=%h expected=not 7777", rd);
        end
`else
        chk("nowp_st_err", 16'(er), 16'd0);
        a_txn(1'b0, 16'h0010, 16'h0, rd, er, lat);
        chk("nowp_ld", rd, 16'h7777);
`endif
        a_txn(1'b1, 16'h0100, 16'h4242, rd, er, lat);
        chk("wp_edge_err", 16'(er), 16'd0);
        a_txn(1'b0, 16'h0100, 16'h0, rd, er, lat);
        chk("wp_edge_ld", rd, 16'h4242);

        // Zero wait states, req held high: ack on alternate cycles
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'hFF01;
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("b2b_ack%0d", i), 16'(b_ack), 16'(i % 2 == 0));
            chk($sformatf("b2b_busy%0d", i), 16'(b_busy), 16'(i % 2 == 0));
            if (b_ack) nack++;
            if (i == 4) chk("b2b_cnt3", b_rdata, 16'h0002);
        end
        b_req = 1'b0;
        chk("b2b_accepted", 16'(nack), 16'd3);
        tick();
        chk("b2b_idle", 16'(b_busy), 16'd0);
        chk("b2b_hold", b_rdata, 16'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning RAM depth 2^ADDR_W words of 16 bits.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..7, meaning wait states inserted before ack.
REQ-003 SHALL have parameter IO_BASE, default 16'hFF00, meaning base address of the memory-mapped IO window.
REQ-004 SHALL have one clock, clk; reset is synchronous and active-high, port name reset.
REQ-005 SHALL have ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- req  in  1  CPU load/store request
- we  in  1  1 = store, 0 = load
- addr  in  16  word address
- wdata  in  16  store data
- io_in  in  16  external input (switches)
- rdata  out  16  load data
- ack  out  1  one-cycle transaction-complete pulse
- busy  out  1  transaction in progress, req ignored
- err  out  1  one-cycle error pulse, coincident with ack
- io_out  out  16  output register (LEDs)

Function
REQ-006 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-007 SHALL accept a request in IDLE when req=1, capturing addr, wdata and we on that edge.
REQ-008 SHALL go IDLE->WAIT on accept if WAIT_CYCLES>0, else IDLE->ACK.
REQ-009 SHALL stay in WAIT for exactly WAIT_CYCLES cycles, counted by a 3-bit down-counter, then go WAIT->ACK.
REQ-010 SHALL hold ACK for one cycle, then return to IDLE.
REQ-011 SHALL assert ack only in ACK, giving ack high WAIT_CYCLES+1 cycles after the accepting edge.
REQ-012 SHALL drive busy high in WAIT and ACK, and ignore req in those states.
REQ-013 SHALL allow back-to-back requests: a req seen in the cycle after ACK, in IDLE, is accepted.
REQ-014 SHALL decode captured addresses as follows:
- addr < 2^ADDR_W: RAM
- addr == IO_BASE: IO register, writes io_out, reads io_in
- addr == IO_BASE+1: read-only transaction counter
- anything else: unmapped
REQ-015 SHALL perform RAM and io_out writes only on the clock edge ending the ACK cycle.
REQ-016 SHALL drive rdata with registered load data during the ACK cycle and hold it until the next ACK cycle.
REQ-017 SHALL leave rdata unchanged on stores.
REQ-018 SHALL treat unmapped accesses and stores to IO_BASE+1 as errors: err=1 with ack, no state change, rdata=0 for loads.
REQ-019 SHALL increment the transaction counter on every ack, including errors, wrapping 16'hFFFF->0.
REQ-020 SHALL return the counter value from before the current transaction when IO_BASE+1 is read.
REQ-021 SHALL sample io_in during the ACK cycle for loads of IO_BASE.

Reset
REQ-022 SHALL on reset set state=IDLE, ack=0, busy=0, err=0, rdata=0, io_out=0, counter=0 and wait count=0.
REQ-023 SHALL not initialise RAM contents on reset.
REQ-024 SHALL abort any in-flight transaction on reset asserted mid-operation: no write, no ack, and reset has priority over all events.

Configuration
REQ-025 SHALL, when macro MEM_RESP_WRITE_PROTECT_EN is defined, reject stores to addresses 0x0000..0x00FF (RAM unchanged, err=1 with ack); loads are unaffected.
REQ-026 SHALL, without MEM_RESP_WRITE_PROTECT_EN, treat all RAM addresses as writable.

Verification
REQ-027 SHALL cover, with WAIT_CYCLES=1: store 0x1234 to 0x0200, then load 0x0200 -> each ack 2 cycles after accept; rdata=0x1234, err=0.
REQ-028 SHALL cover a store of 0xA5A5 to 0xFF00, then a load of 0xFF00 with io_in=0x00F0 -> io_out=0xA5A5 after store ack; rdata=0x00F0.
REQ-029 SHALL cover a load of 0x8000 -> ack and err together, rdata=0; then a load of 0xFF01 -> rdata=0x0001.
REQ-030 SHALL cover req held high for 6 cycles with WAIT_CYCLES=0 -> ack every 2nd cycle, busy toggling, 3 transactions accepted.
REQ-031 SHALL cover reset asserted in the WAIT state of a store of 0xBEEF to 0x0300 -> no ack; a later load of 0x0300 returns the old value; counter=0.
REQ-032 SHALL cover, with MEM_RESP_WRITE_PROTECT_EN defined, a store to 0x0010 -> err=1 and RAM unchanged; without the macro -> write succeeds, err=0.
